lsu_align: RTL
==============

# lsu_align

Load/store alignment unit between the core's execute stage and the word-addressed data memory. Converts byte/half/word load and store requests (RISC-V funct3 encoding) into lane-correct byte enables and shifted write data, extracts and sign/zero-extends load data from the returned word, and, when enabled, splits word-crossing misaligned accesses into two memory beats while stalling the core.

## Interface

- No parameters; data and address width fixed at 32.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: memory instruction valid this cycle.
- `we` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 b, 001 h, 010 w, 100 bu, 101 hu; stores use [1:0].
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `rdata` out 32: extended load result.
- `stall` out 1: core must hold all inputs and not advance PC.
- `misalign_err` out 1: misaligned access rejected (split disabled).
- `dm_we` out 1: memory write enable.
- `dm_a` out 32: memory byte address, bits [1:0] always 00.
- `dm_wd` out 32: lane-aligned write data.
- `dm_be` out 4: byte lane enables, bit i = byte i.
- `dm_rd` in 32: memory read word, combinational from `dm_a`.

## Operation

- Size mask m: b = 0001, h = 0011, w = 1111. off = addr[1:0]. Shifted mask M = m << off (7 bits).
- Illegal funct3 (011, 110, 111, or store with [1:0]=11): no access, dm_we=0, rdata=0, stall=0, misalign_err=1 for that cycle.
- Aligned (M[6:4]==0): single beat, combinational. dm_a = {addr[31:2],00}, dm_be = M[3:0], dm_wd = wdata << 8*off, dm_we = req & we. Load: raw = dm_rd >> 8*off; rdata = raw masked to size, sign-extended from bit 7/15 for b/h, zero-extended for bu/hu.
- Misaligned (M[6:4]!=0), see Configuration.
- FSM: IDLE, SECOND. IDLE → SECOND on req & misaligned & split enabled; SECOND → IDLE unconditionally next cycle.
- IDLE beat of a split: dm_a = {addr[31:2],00}, dm_be = M[3:0], dm_wd = wdata << 8*off; load captures lo_reg <= dm_rd >> 8*off at the clock edge; stall=1.
- SECOND beat: dm_a = {addr[31:2],00} + 4, dm_be = {0,M[6:4]}, dm_wd = wdata >> 8*(4-off); load raw = lo_reg | (dm_rd << 8*(4-off)), then extended as above; stall=0.
- Address wrap at 0xFFFFFFFC + 4 wraps to 0x00000000.
- req=0: dm_we=0, dm_be=0000, rdata=0; dm_a still follows addr.

## Timing

- Reset (rst_n low, async): state IDLE, lo_reg=0; while low, dm_we=0, stall=0, misalign_err=0, rdata=0.
- Aligned access: zero-cycle latency; rdata valid same cycle; write committed at next rising edge.
- Split access: 2 cycles; stall high in cycle 1 only; rdata valid in cycle 2; core holds req/we/funct3/addr/wdata stable across both cycles (inputs in SECOND taken from the held values, not re-latched).
- Reset asserted during SECOND: return to IDLE; first-beat store already committed stays committed; no second write.
- misalign_err is combinational, one cycle per rejected request.

## Configuration

- `LSU_MISALIGN_SPLIT_EN` defined: misaligned accesses split as above; misalign_err only for illegal funct3.
- Not defined: SECOND state and lo_reg removed; misaligned request gives dm_we=0, dm_be=0000, rdata=0, stall=0, misalign_err=1.

## Test plan

- lw addr 0x10, dm_rd 0x8899AABB -> dm_a 0x10, dm_be 1111, rdata 0x8899AABB, stall 0.
- lb addr 0x13 with dm_rd 0x80112233 -> rdata 0xFFFFFF80; lbu same -> 0x00000080.
- sh addr 0x22, wdata 0x0000BEEF -> dm_a 0x20, dm_be 1100, dm_wd 0xBEEF0000, dm_we 1.
- Split enabled, sw addr 0x41, wdata 0xAABBCCDD -> cycle 1: dm_a 0x40, be 1110, wd 0xBBCCDD00, stall 1; cycle 2: dm_a 0x44, be 0001, wd 0x000000AA, stall 0.
- Split enabled, lh addr 0x43, words 0x11xxxxxx at 0x40 and 0xxxxxxx92 at 0x44 -> cycle 2 rdata 0xFFFF9211; reset pulse mid-split returns to IDLE, stall 0.
- Split disabled, lw addr 0x02 -> misalign_err 1, dm_we 0, rdata 0; funct3 011 -> misalign_err 1.

Source files
------------

// File: rtl/lsu_align_if.sv
// lsu_align_if: groups the core-side request/response and the data-memory port of lsu_align.
// Latency: none (plain signal bundle).
// Backpressure: stall travels core-ward through this bundle; no other flow control.
// Ports: req/we/funct3/addr/wdata in from the core, rdata/stall/misalign_err back to it;
//        dm_we/dm_a/dm_wd/dm_be out to memory, dm_rd back from memory (combinational on dm_a).
//        master = environment side (core + memory), slave = the alignment unit.
interface lsu_align_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign_err;
  logic        dm_we;
  logic [31:0] dm_a;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_rd;

  modport master (
    output req, we, funct3, addr, wdata, dm_rd,
    input  rdata, stall, misalign_err, dm_we, dm_a, dm_wd, dm_be
  );

  modport slave (
    input  req, we, funct3, addr, wdata, dm_rd,
    output rdata, stall, misalign_err, dm_we, dm_a, dm_wd, dm_be
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte/half/word load-store alignment between execute stage and word-addressed data memory.
// Latency: aligned accesses are combinational (0 cycles); split word-crossing accesses take 2 cycles.
// Backpressure: stall is high during the first beat of a split; the core holds all inputs until it drops.
// Ports: clk, rst_n (async active-low); bus (lsu_align_if.slave) carries core request/response and memory port.
// Option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats; when undefined
//         they are rejected with misalign_err and no state is kept.
module lsu_align (
  input  logic       clk,
  input  logic       rst_n,
  lsu_align_if.slave bus
);

  logic [1:0]  off;
  logic [4:0]  sh_lo;       // 8*off
  logic [4:0]  sh_hi;       // 32 - 8*off (mod 32), only used when off != 0
  logic [3:0]  size_mask;
  logic [6:0]  lane_mask;   // size mask shifted to the byte offset, may spill into the next word
  logic [31:0] word_a;
  logic        illegal;
  logic        misaligned;
  logic [31:0] lo_raw;
  logic [31:0] hi_raw;
  logic        in_second;
  logic        split_start;

  assign off   = bus.addr[1:0];
  assign sh_lo = {off, 3'b000};
  assign sh_hi = 5'd0 - sh_lo;

  always_comb begin
    case (bus.funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign lane_mask  = {3'b000, size_mask} << off;
  assign misaligned = |lane_mask[6:4];
  assign word_a     = {bus.addr[31:2], 2'b00};
  assign lo_raw     = bus.dm_rd >> sh_lo;

  // A store with funct3[1:0]==11 is funct3 011 or 111, both already in this set.
  assign illegal = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extend = {24'b0, raw[7:0]};
      3'b101:  extend = {16'b0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] lo_reg;    // low-word bytes of a split load, already shifted down

  assign split_start = bus.req && !illegal && misaligned && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo_reg <= '0;
    end else begin
      state <= state_nxt;
      if (split_start && !bus.we) begin
        lo_reg <= lo_raw;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (split_start) state_nxt = SECOND;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_second = (state == SECOND);
  // High-word bytes land above the ones captured from the first beat.
  assign hi_raw    = lo_reg | (bus.dm_rd << sh_hi);
`else
  assign in_second   = 1'b0;
  assign split_start = 1'b0;
  assign hi_raw      = '0;
  // Without the split path the unit is purely combinational.
  wire unused_clk = clk;
`endif

  always_comb begin
    bus.dm_a         = word_a;
    bus.dm_we        = 1'b0;
    bus.dm_be        = 4'b0000;
    bus.dm_wd        = bus.wdata << sh_lo;
    bus.rdata        = '0;
    bus.stall        = 1'b0;
    bus.misalign_err = 1'b0;
    if (rst_n) begin
      if (in_second) begin
        // Inputs are still held by the core, so the same offset/size drive the upper beat.
        bus.dm_a  = word_a + 32'd4;
        bus.dm_be = {1'b0, lane_mask[6:4]};
        bus.dm_wd = bus.wdata >> sh_hi;
        bus.dm_we = bus.req && bus.we;
        if (bus.req && !bus.we) begin
          bus.rdata = extend(bus.funct3, hi_raw);
        end
      end else if (bus.req) begin
        if (illegal || (misaligned && !split_start)) begin
          bus.misalign_err = 1'b1;
        end else begin
          bus.dm_be = lane_mask[3:0];
          bus.dm_we = bus.we;
          if (split_start) begin
            bus.stall = 1'b1;
          end else if (!bus.we) begin
            bus.rdata = extend(bus.funct3, lo_raw);
          end
        end
      end
    end
  end

endmodule
